// File: rtl/mxgen_pkg.sv
// Shared types and constants for the mxtest_gen packet source.
// Includes the payload modes, the FSM states, the framing bytes and the PRBS-8 polynomial.
package mxgen_pkg;

  typedef enum logic [1:0] {
    MX_ROM  = 2'd0,
    MX_PRBS = 2'd1,
    MX_CNT  = 2'd2,
    MX_RSVD = 2'd3
  } mx_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_RDY,
    ST_GAP,
    ST_HOLD
  } mx_state_t;

  localparam logic [7:0] MX_PRE       = 8'h55;
  localparam logic [7:0] MX_SFD       = 8'hD0;
  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] MX_PRBS_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & MX_PRBS_TAPS)};
  endfunction

endpackage

// File: rtl/mxgen_lfsr.sv
// 8-bit Fibonacci PRBS-8 generator, shifting left.
// It has a synchronous reseed input and a separate step input.
module mxgen_lfsr
  import mxgen_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] value
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (adv) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/mxtest_gen.sv
// Packet source for the Manchester TX/RX loop: preamble, SFD, then ROM/PRBS/counter payload.
// Bytes are handed over one at a time using the transmitter's ready/send handshake.
module mxtest_gen
  import mxgen_pkg::*;
#(
  parameter int         W_LEN      = 6,
  parameter int         PRE_BYTES  = 2,
  parameter int         ROM_DEPTH  = 64,
  parameter int         GAP_CYCLES = 1000,
  parameter logic [7:0] LFSR_SEED  = 8'hFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic [W_LEN-1:0] length,
  input  logic             rpt,
  input  logic             ready,
  output logic             send,
  output logic [7:0]       data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pkt_count
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [W_LEN-1:0] PRE_IDX  = W_LEN'(PRE_BYTES);

  mx_state_t        state, state_nxt;
  mx_mode_t         mode_q;
  logic [W_LEN-1:0] idx, len;
  logic [W_LEN:0]   idx_inc;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       lfsr_q, byte_nxt;
  logic             is_payload;
  logic             lfsr_load, lfsr_adv, fire, load_pkt, step_idx, pkt_end, gap_tick;

  // Payload ROM, indexed by byte position within the packet.
  function automatic logic [7:0] rom_byte(input logic [W_LEN-1:0] a);
    logic [7:0] b;
    case (int'(a))
      0:  b = 8'h4D;  1:  b = 8'h41;  2:  b = 8'h4E;  3:  b = 8'h43;
      4:  b = 8'h48;  5:  b = 8'h45;  6:  b = 8'h53;  7:  b = 8'h54;
      8:  b = 8'h45;  9:  b = 8'h52;  10: b = 8'h20;  11: b = 8'h54;
      12: b = 8'h45;  13: b = 8'h53;  14: b = 8'h54;  15: b = 8'h21;
      default: b = 8'hA0 ^ 8'(a);
    endcase
    if (int'(a) >= ROM_DEPTH) b = 8'h00;
    return b;
  endfunction

  mxgen_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .adv     (lfsr_adv),
    .value   (lfsr_q)
  );

  assign idx_inc = {1'b0, idx} + (W_LEN + 1)'(1);

  always_comb begin
    is_payload = (idx > PRE_IDX);
    if (idx < PRE_IDX) begin
      byte_nxt = MX_PRE;
    end else if (idx == PRE_IDX) begin
      byte_nxt = MX_SFD;
    end else begin
      case (mode_q)
        MX_PRBS: byte_nxt = lfsr_q;
        MX_CNT:  byte_nxt = 8'(idx);
        default: byte_nxt = rom_byte(idx);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    fire      = 1'b0;
    load_pkt  = 1'b0;
    step_idx  = 1'b0;
    pkt_end   = 1'b0;
    gap_tick  = 1'b0;
    case (state)
      ST_IDLE: if (run) begin
        lfsr_load = 1'b1;
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_pkt = 1'b1;
        if (length == '0) begin
          pkt_end   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: if (ready) begin
        fire      = 1'b1;
        lfsr_adv  = is_payload && (mode_q == MX_PRBS);
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: if (!ready) state_nxt = ST_WAIT_RDY;
      ST_WAIT_RDY: if (ready) begin
        step_idx = 1'b1;
        if (idx_inc < {1'b0, len}) begin
          state_nxt = ST_SEND;
        end else begin
          pkt_end   = 1'b1;
          state_nxt = (rpt && run) ? ST_GAP : ST_HOLD;
        end
      end
      // The PRBS keeps running across repeated packets, so no reseed on the way back to LOAD.
      ST_GAP: begin
        if (!run)                    state_nxt = ST_IDLE;
        else if (gap_cnt == GAP_LAST) state_nxt = ST_LOAD;
        else                         gap_tick  = 1'b1;
      end
      ST_HOLD: if (!run) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      send      <= 1'b0;
      data      <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_count <= 16'h0000;
      idx       <= '0;
      len       <= '0;
      mode_q    <= MX_ROM;
      gap_cnt   <= '0;
    end else begin
      send <= fire;
      done <= pkt_end;
      busy <= !(state_nxt inside {ST_IDLE, ST_HOLD});
      if (fire)    data      <= byte_nxt;
      if (pkt_end) pkt_count <= pkt_count + 16'd1;
      if (load_pkt) begin
        len    <= length;
        idx    <= '0;
        mode_q <= mx_mode_t'(mode);
      end else if (step_idx) begin
        idx <= idx_inc[W_LEN-1:0];
      end
      if (state != ST_GAP) gap_cnt <= '0;
      else if (gap_tick)   gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule
